// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the memory sequencer, the RAM and the control unit.
// MEM_DEPTH is derived from ADDR_W so the two can never disagree.
package mem_pkg;

    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_DEPTH = 1 << DEF_ADDR_W;

    // Sequencer states; the encoding is shared with anything that decodes them.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request bus of the memory sequencer (MAR/MDR handshake).
// master = control unit, slave = mem_access_ctrl.
interface mem_access_ctrl_if
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mar_in;
    logic [DATA_W-1:0] mdr_in;
    logic [DATA_W-1:0] mdr_out;
    logic              mem_busy;
    logic              mem_done;
    logic              mem_fault;

    modport master (
        output mem_req, mem_we, mar_in, mdr_in,
        input  mdr_out, mem_busy, mem_done, mem_fault
    );

    modport slave (
        input  mem_req, mem_we, mar_in, mdr_in,
        output mdr_out, mem_busy, mem_done, mem_fault
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// Sequencer between the CPU control unit and a 512x32 synchronous RAM.
// One request at a time: IDLE -> ACCESS (one-cycle strobe) -> [CAPTURE] -> DONE.
// Optional macro MEM_FAULT_EN: out-of-range MAR values fault instead of wrapping.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clock,
    input  logic                clear_n,
    mem_access_ctrl_if.slave    cpu,
    input  logic [DATA_W-1:0]   ram_data_out,
    output logic                read,
    output logic                write,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   ram_data_in
);

    mem_state_t        state;
    logic              we_q;
    logic              read_q;
    logic              write_q;
    logic [DATA_W-1:0] mdr_q;
    logic              busy_q;
    logic              done_q;

`ifdef MEM_FAULT_EN
    logic fault_q;
    logic range_err;
    assign range_err     = |cpu.mar_in[DATA_W-1:ADDR_W];
    assign cpu.mem_fault = fault_q;
`else
    // Upper MAR bits are deliberately dropped: addresses wrap modulo the RAM depth.
    logic unused_upper;
    assign unused_upper  = ^cpu.mar_in[DATA_W-1:ADDR_W];
    assign cpu.mem_fault = 1'b0;
`endif

    // Strobes are gated by clear_n so a reset cycle can never write the RAM.
    assign read  = read_q  & clear_n;
    assign write = write_q & clear_n;

    assign cpu.mdr_out  = mdr_q;
    assign cpu.mem_busy = busy_q;
    assign cpu.mem_done = done_q;

    // Single FSM; all outputs registered and set on entry to the state that shows them.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address     <= '0;
            ram_data_in <= '0;
            mdr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MEM_FAULT_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            // Strobes and pulses last exactly one cycle unless re-armed below.
            read_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_FAULT_EN
            fault_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (cpu.mem_req) begin
                        busy_q <= 1'b1;
`ifdef MEM_FAULT_EN
                        if (range_err) begin
                            // Skip the RAM entirely; address/data/MDR keep their values.
                            state   <= S_DONE;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            state       <= S_ACCESS;
                            we_q        <= cpu.mem_we;
                            address     <= cpu.mar_in[ADDR_W-1:0];
                            ram_data_in <= cpu.mdr_in;
                            write_q     <= cpu.mem_we;
                            read_q      <= ~cpu.mem_we;
                        end
                    end
                end
                S_ACCESS: begin
                    if (we_q) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // RAM data is valid the cycle after the address was sampled.
                    mdr_q  <= ram_data_out;
                    state  <= S_DONE;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a behavioural 512x32 RAM attached.
// Reference model: word array + last-read register, updated per transaction.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic [31:0] ram_data_out;
    logic        read, write;
    logic [8:0]  address;
    logic [31:0] ram_data_in;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .cpu          (bus.slave),
        .ram_data_out (ram_data_out),
        .read         (read),
        .write        (write),
        .address      (address),
        .ram_data_in  (ram_data_in)
    );

    always #5 clock = ~clock;

    // RAM under the sequencer, plus a back-door preload port
    logic [31:0] ram [512];
    logic        pre_we = 1'b0;
    logic [8:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clock) begin
        if (pre_we)     ram[pre_addr] <= pre_data;
        else if (write) ram[address]  <= ram_data_in;
        if (read)       ram_data_out  <= ram[address];
    end

    logic [31:0] ref_mem [512];
    logic [31:0] ref_mdr;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clock);
        pre_we = 1'b1; pre_addr = 9'(a); pre_data = d;
        @(negedge clock);
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    function automatic logic faulty(input logic [31:0] mar);
`ifdef MEM_FAULT_EN
        return mar[31:9] != 23'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request and watch 8 cycles after the accepting edge.
    task automatic op(input logic we, input logic [31:0] mar, input logic [31:0] din,
                      output int done_at, output int nrd, output int nwr,
                      output logic [8:0] sa, output logic [31:0] wd,
                      output logic [31:0] md, output logic fs);
        done_at = -1; nrd = 0; nwr = 0; sa = '0; wd = '0; md = '0; fs = 1'b0;
        @(negedge clock);
        bus.mem_req = 1'b1; bus.mem_we = we; bus.mar_in = mar; bus.mdr_in = din;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 1) begin
                bus.mem_req = 1'b0;
                bus.mem_we  = 1'($urandom_range(0, 1));
                bus.mar_in  = $urandom;
                bus.mdr_in  = $urandom;
            end
            if (read)  nrd++;
            if (write) begin nwr++; wd = ram_data_in; end
            if (read || write) sa = address;
            if (bus.mem_done && done_at < 0) begin
                done_at = c; md = bus.mdr_out; fs = bus.mem_fault;
            end
        end
    endtask

    task automatic run_op(input logic we, input logic [31:0] mar, input logic [31:0] din, input string tag);
        int done_at, nrd, nwr, a;
        logic [8:0] sa;
        logic [31:0] wd, md;
        logic fs;
        op(we, mar, din, done_at, nrd, nwr, sa, wd, md, fs);
        a = int'(mar[8:0]);
        if (faulty(mar)) begin
            chk({tag, "_lat"},   64'(done_at), 64'(1));
            chk({tag, "_strb"},  64'(nrd + nwr), 64'(0));
            chk({tag, "_fault"}, 64'(fs), 64'(1));
            chk({tag, "_mdr"},   64'(md), 64'(ref_mdr));
        end else begin
            chk({tag, "_lat"},   64'(done_at), 64'(we ? 2 : 3));
            chk({tag, "_nrd"},   64'(nrd), 64'(we ? 0 : 1));
            chk({tag, "_nwr"},   64'(nwr), 64'(we ? 1 : 0));
            chk({tag, "_addr"},  64'(sa), 64'(a));
            chk({tag, "_fault"}, 64'(fs), 64'(0));
            if (we) begin
                chk({tag, "_wdata"}, 64'(wd), 64'(din));
                chk({tag, "_mdr"},   64'(md), 64'(ref_mdr));
                ref_mem[a] = din;
            end else begin
                ref_mdr = ref_mem[a];
                chk({tag, "_mdr"}, 64'(md), 64'(ref_mdr));
            end
        end
    endtask

    initial begin
        int dones;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mar_in = '0; bus.mdr_in = '0;
        ref_mdr = '0;

        // Clear the RAM while held in reset
        for (int i = 0; i < 512; i++) begin
            @(negedge clock);
            pre_we = 1'b1; pre_addr = 9'(i); pre_data = '0;
            ref_mem[i] = '0;
        end
        @(negedge clock);
        pre_we = 1'b0;

        // Reset state
        chk("rst_ctl",  64'({read, write, bus.mem_busy, bus.mem_done, bus.mem_fault}), 64'(0));
        chk("rst_addr", 64'(address), 64'(0));
        chk("rst_wdat", 64'(ram_data_in), 64'(0));
        chk("rst_mdr",  64'(bus.mdr_out), 64'(0));

        // Release with no request: stays idle
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rel_idle", 64'({read, write, bus.mem_busy, bus.mem_done}), 64'(0));
        end

        // Directed: read, write, read-back, wrapped address
        poke(149, 32'h22);
        run_op(1'b0, 32'h95, 32'h0, "t1_rd95");
        run_op(1'b1, 32'h87, 32'hDEADBEEF, "t2_wr87");
        run_op(1'b0, 32'h87, 32'h0, "t2_rd87");
        run_op(1'b0, 32'h0000_0295, 32'h0, "t5_rd295");

        // Back-to-back reads with req held high: done every 4 cycles
        poke(32'h5A, 32'h12);
        dones = 0;
        @(negedge clock);
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mar_in = 32'h5A;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clock);
            if (bus.mem_done) begin
                dones++;
                chk("t3_phase", 64'(c % 4), 64'(3));
                chk("t3_mdr",   64'(bus.mdr_out), 64'(32'h12));
            end
        end
        bus.mem_req = 1'b0;
        chk("t3_count", 64'(dones), 64'(3));
        repeat (4) @(negedge clock);
        chk("t3_idle", 64'(bus.mem_busy), 64'(0));
        ref_mdr = 32'h12;

        // Reset during the ACCESS cycle of a write
        poke(32'h10, 32'h0);
        @(negedge clock);
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mar_in = 32'h10; bus.mdr_in = 32'hCAFEF00D;
        @(negedge clock);
        bus.mem_req = 1'b0;
        chk("t4_wr_armed", 64'(write), 64'(1));
        clear_n = 1'b0;
        #1;
        chk("t4_wr_gated", 64'(write), 64'(0));
        @(negedge clock);
        chk("t4_ctl",  64'({read, write, bus.mem_busy, bus.mem_done, bus.mem_fault}), 64'(0));
        chk("t4_addr", 64'(address), 64'(0));
        chk("t4_wdat", 64'(ram_data_in), 64'(0));
        chk("t4_mdr",  64'(bus.mdr_out), 64'(0));
        clear_n = 1'b1;
        ref_mdr = '0;
        run_op(1'b0, 32'h10, 32'h0, "t4_rd10");

        // Randomized mix over a small address window, some with upper MAR bits set
        for (int n = 0; n < 40; n++) begin
            logic [31:0] mar;
            mar = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) mar = mar | ($urandom_range(1, 7) << 9);
            run_op(1'($urandom_range(0, 1)), mar, $urandom, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
